fifo_mem_pipe: RTL
==================

Name: fifo_mem_pipe

Overview:
Next-generation FIFO storage array: a dual-port memory, one write port and one read port, sitting under the FIFO pointer/flag logic.
- Generalised in width and depth, with per-lane (byte-granular) write enables.
- Registered, enable-gated read with a configurable 1- or 2-cycle pipeline and a matching valid strobe.
- Selectable same-address read/write collision semantics.
- Optional self-clearing of the whole array after reset, driven by an internal sequencer.

Parameters:
DWIDTH, 32, data width in bits; must be a multiple of LANE.
AWIDTH, 4, address width; DEPTH = 2**AWIDTH.
LANE, 8, bits per write-enable lane; NLANE = DWIDTH/LANE.
RD_LATENCY, 1, read latency in cycles, 1 or 2; any other value is an elaboration error.
RW_MODE, RF, collision mode on same-address read and write in one cycle: RF = read-first, WF = write-first.
INIT_ON_RESET, 1, 1 = zero every entry after reset; 0 = contents undefined after reset.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wren  in  1  write request
wbe  in  NLANE  lane write enables; qualified by wren
waddr  in  AWIDTH  write address
wdata  in  DWIDTH  write data
rden  in  1  read request
raddr  in  AWIDTH  read address
rdata  out  DWIDTH  read data, registered
rvalid  out  1  rdata holds the result of a read issued RD_LATENCY cycles earlier
init_busy  out  1  array clear in progress; wren/rden ignored

Behaviour:
- Reset (rst=1 at an edge):
  - rdata<=0, rvalid<=0, all read-pipe stages cleared.
  - Init FSM -> INIT with counter cnt<=0 if INIT_ON_RESET=1, else -> IDLE.
  - init_busy=1 combinationally while rst=1 or FSM=INIT.
  - Memory contents are not touched by rst itself.
- Init FSM, states IDLE and INIT:
  - In INIT, each edge with rst=0 writes 0 to mem[cnt] and increments cnt.
  - The edge that writes cnt=DEPTH-1 moves the FSM to IDLE.
  - Clear takes exactly DEPTH cycles after rst falls; init_busy=0 in the next cycle.
  - rst asserted mid-INIT restarts from cnt=0.
  - cnt is AWIDTH+1 bits so it does not wrap early.
- While init_busy=1: wren and rden are ignored; no pipeline stage asserts valid.
- Write: at an edge with wren=1, lane i of mem[waddr] <= wdata lane i for each i with wbe[i]=1; other lanes keep their value. wren=1 with wbe all zero leaves the array unchanged.
- Read:
  - At edge k with rden=1, the array word at raddr is captured.
  - RD_LATENCY=1: rdata and rvalid=1 appear after edge k.
  - RD_LATENCY=2: one extra register stage; rdata/rvalid appear after edge k+1.
  - Back-to-back reads give one result per cycle.
  - rvalid is 0 in any output cycle with no matching read.
  - rdata holds its last value when rvalid=0; it is never cleared except by reset.
- Collision (same edge, wren=1, rden=1, waddr==raddr):
  - RF: read returns the pre-write word.
  - WF: read returns the merged word (enabled lanes from wdata, the rest old).
  - Addresses that differ do not interact.
- Write and read of the same address on successive edges always returns the new data, in both modes.
- Boundaries: address DEPTH-1 is handled like any other address; there is no wrap logic here. Full/empty is the owner's responsibility.

Decomposition:
- Package fifo_mem_pkg holds:
  - rw_mode_e {RF, WF}
  - init_state_e {IDLE, INIT}
  - function nlane(DWIDTH, LANE)
- One sub-module, fifo_mem_init: the init FSM plus counter. Outputs init_busy, init_we, init_addr; the top muxes these onto the write port.
- The top holds the array, lane-merge logic, collision mux and the read pipeline (generate on RD_LATENCY).

Test Plan:
1. Reset release, INIT_ON_RESET=1, AWIDTH=4: rst high 2 cycles then low -> init_busy high for exactly 16 cycles after rst falls; reads of addr 0..15 then return 0; rvalid=0 throughout the clear.
2. Byte enables, DWIDTH=32: write 0xAABBCCDD to addr 3 with wbe=1111, then 0x11223344 with wbe=0101 -> reading addr 3 returns 0xAA22CC44.
3. Latency: RD_LATENCY=2, rden pulsed at edges 10, 11, 12 (addrs 1, 2, 3 preloaded 0x1, 0x2, 0x3) -> rvalid high after edges 11, 12, 13 with rdata 0x1, 0x2, 0x3; rvalid=0 after edge 14 while rdata holds 0x3.
4. Collision: addr 5 holds 0x0; same edge wren=1, wbe=1111, wdata=0x55, rden=1, raddr=5 -> RF returns 0x0, WF returns 0x55; next read of addr 5 returns 0x55 in both modes.
5. Reset mid-init: rst reasserted at cnt=7 -> clear restarts; init_busy stays high 16 cycles after the second rst falls; wren pulsed during init leaves the target entry 0.
6. Ignored access: wren=1 with wbe=0000 at addr 9 -> contents unchanged; rden=1 during rst -> no rvalid after reset.

Source files
------------

// File: rtl/fifo_mem_pkg.sv
// Shared types and helpers for the FIFO storage array.
//   rw_mode_e    : same-address read/write collision behaviour (RF = read-first, WF = write-first)
//   init_state_e : post-reset clear sequencer states
//   nlane()      : number of byte-enable lanes for a given data/lane width
package fifo_mem_pkg;

  typedef enum logic {RF, WF} rw_mode_e;

  typedef enum logic {IDLE, INIT} init_state_e;

  function automatic int unsigned nlane(int unsigned dwidth, int unsigned lane);
    return dwidth / lane;
  endfunction

endpackage

// File: rtl/fifo_mem_init.sv
// Post-reset clear sequencer for the FIFO storage array.
// Walks every address once after reset and requests a zero write to each.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high; restarts the clear from address 0
//   init_busy : clear in progress (also high while rst is held)
//   init_we   : write-zero request for init_addr this cycle
//   init_addr : address being cleared
module fifo_mem_init
  import fifo_mem_pkg::*;
#(
  parameter int unsigned AWIDTH        = 4,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic              init_we,
  output logic [AWIDTH-1:0] init_addr
);

  localparam int unsigned      DEPTH = 2 ** AWIDTH;
  // One extra counter bit so the counter never wraps before the last entry is cleared.
  localparam logic [AWIDTH:0]  LAST  = (AWIDTH + 1)'(DEPTH - 1);
  localparam logic [AWIDTH:0]  ONE   = (AWIDTH + 1)'(1);

  init_state_e       state, state_next;
  logic [AWIDTH:0]   cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_ON_RESET) state <= INIT;
      else               state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_we    = 1'b0;
    init_busy  = rst || (state == INIT);
    if ((state == INIT) && !rst) begin
      init_we  = 1'b1;
      cnt_next = cnt + ONE;
      if (cnt == LAST) state_next = IDLE;
    end
  end

  assign init_addr = cnt[AWIDTH-1:0];

endmodule

// File: rtl/fifo_mem_pipe.sv
// FIFO storage array: one write port with byte-lane enables, one registered
// read port with 1- or 2-cycle latency and a matching valid strobe,
// selectable same-address collision semantics and optional post-reset clear.
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high (does not touch array contents)
//   wren      : write request
//   wbe       : lane write enables, qualified by wren
//   waddr     : write address
//   wdata     : write data
//   rden      : read request
//   raddr     : read address
//   rdata     : registered read data, holds when rvalid is low
//   rvalid    : rdata carries a read issued RD_LATENCY cycles earlier
//   init_busy : array clear in progress; wren/rden ignored
module fifo_mem_pipe
  import fifo_mem_pkg::*;
#(
  parameter int unsigned DWIDTH        = 32,
  parameter int unsigned AWIDTH        = 4,
  parameter int unsigned LANE          = 8,
  parameter int unsigned RD_LATENCY    = 1,
  parameter rw_mode_e    RW_MODE       = RF,
  parameter bit          INIT_ON_RESET = 1'b1,
  localparam int unsigned NLANE        = nlane(DWIDTH, LANE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic [NLANE-1:0]  wbe,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rden,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("fifo_mem_pipe: RD_LATENCY must be 1 or 2");
  end
  if ((DWIDTH % LANE) != 0) begin : g_bad_lane
    $error("fifo_mem_pipe: DWIDTH must be a multiple of LANE");
  end

  logic              init_we;
  logic [AWIDTH-1:0] init_addr;

  fifo_mem_init #(
    .AWIDTH        (AWIDTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              wr_active, rd_active;
  logic [DWIDTH-1:0] merged, rd_word;

  assign wr_active = wren && !init_busy;
  assign rd_active = rden && !init_busy;

  // Word as it will look after this cycle's write: enabled lanes from wdata.
  always_comb begin
    merged = mem[waddr];
    for (int unsigned i = 0; i < NLANE; i++) begin
      if (wbe[i]) merged[i*LANE +: LANE] = wdata[i*LANE +: LANE];
    end
  end

  // Write-first forwards the merged word; read-first sees the array as-is.
  always_comb begin
    rd_word = mem[raddr];
    if ((RW_MODE == WF) && wr_active && (waddr == raddr)) rd_word = merged;
  end

  // Clear sequencer owns the write port while busy; user writes are blocked then.
  always_ff @(posedge clk) begin
    if (init_we)        mem[init_addr] <= '0;
    else if (wr_active) mem[waddr]     <= merged;
  end

  logic              s1_valid;
  logic [DWIDTH-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_active;
      if (rd_active) s1_data <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              s2_valid;
    logic [DWIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rdata  = s2_data;
    assign rvalid = s2_valid;
  end else begin : g_lat1
    assign rdata  = s1_data;
    assign rvalid = s1_valid;
  end

endmodule
